// File: rtl/motor_pkg.sv
// Shared types and defaults for the multi-channel motor sequencer.
package motor_pkg;

  typedef enum logic [2:0] {
    EVAL    = 3'd0,
    WAIT_UP = 3'd1,
    MOVE_UP = 3'd2,
    WAIT_DN = 3'd3,
    MOVE_DN = 3'd4,
    FAULT   = 3'd5
  } ch_state_t;

  localparam int MOTOR_TIMEOUT_DEFAULT = 1000;

endpackage

// File: rtl/motor_ch.sv
// One motor channel: press-to-travel toward the opposite limit, press-to-abort,
// fault on travel timeout or contradictory limits. Outputs registered from next state.
module motor_ch
  import motor_pkg::*;
#(
  parameter int TIMEOUT = MOTOR_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic activate,
  input  logic up_limit,
  input  logic dn_limit,
  input  logic fault_clr,
  output logic motor_up,
  output logic motor_dn,
  output logic fault
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  ch_state_t     state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          act_q;
  logic          act_pulse;

  assign act_pulse = activate & ~act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EVAL;
      timer    <= '0;
      act_q    <= 1'b0;
      motor_up <= 1'b0;
      motor_dn <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      act_q    <= activate;
      motor_up <= (state_n == MOVE_UP);
      motor_dn <= (state_n == MOVE_DN);
      fault    <= (state_n == FAULT);
    end
  end

  // Timer defaults to 0 so it is cleared on every exit and held outside travel.
  always_comb begin
    state_n = state;
    timer_n = '0;
    case (state)
      EVAL: begin
        if (up_limit && dn_limit) state_n = FAULT;
        else if (up_limit)        state_n = WAIT_DN;
        else                      state_n = WAIT_UP;
      end
      WAIT_UP: begin
        if (up_limit)       state_n = EVAL;
        else if (act_pulse) state_n = MOVE_UP;
      end
      WAIT_DN: begin
        if (dn_limit)       state_n = EVAL;
        else if (act_pulse) state_n = MOVE_DN;
      end
      MOVE_UP: begin
        if (up_limit && dn_limit) state_n = FAULT;
        else if (up_limit)        state_n = EVAL;
        else if (timer == T_LAST) state_n = FAULT;
        else if (act_pulse)       state_n = WAIT_DN;
        else                      timer_n = timer + TW'(1);
      end
      MOVE_DN: begin
        if (up_limit && dn_limit) state_n = FAULT;
        else if (dn_limit)        state_n = EVAL;
        else if (timer == T_LAST) state_n = FAULT;
        else if (act_pulse)       state_n = WAIT_UP;
        else                      timer_n = timer + TW'(1);
      end
      FAULT: begin
        if (fault_clr) state_n = EVAL;
      end
      default: state_n = EVAL;
    endcase
  end

endmodule

// File: rtl/motor_ctrl_multi.sv
// N_CH independent motor channels; no shared state between them.
module motor_ctrl_multi
  import motor_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int TIMEOUT = MOTOR_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] activate,
  input  logic [N_CH-1:0] up_limit,
  input  logic [N_CH-1:0] dn_limit,
  input  logic [N_CH-1:0] fault_clr,
  output logic [N_CH-1:0] motor_up,
  output logic [N_CH-1:0] motor_dn,
  output logic [N_CH-1:0] fault
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    motor_ch #(.TIMEOUT(TIMEOUT)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .activate  (activate[i]),
      .up_limit  (up_limit[i]),
      .dn_limit  (dn_limit[i]),
      .fault_clr (fault_clr[i]),
      .motor_up  (motor_up[i]),
      .motor_dn  (motor_dn[i]),
      .fault     (fault[i])
    );
  end

endmodule

// File: tb/tb_motor_ctrl_multi.sv
// Directed per-cycle vector table for a 2-channel, TIMEOUT=8 sequencer plus async-reset sequence.
module tb_motor_ctrl_multi;

  localparam int N_CH    = 2;
  localparam int TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] activate, up_limit, dn_limit, fault_clr;
  logic [N_CH-1:0] motor_up, motor_dn, fault;

  motor_ctrl_multi #(.N_CH(N_CH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .activate  (activate),
    .up_limit  (up_limit),
    .dn_limit  (dn_limit),
    .fault_clr (fault_clr),
    .motor_up  (motor_up),
    .motor_dn  (motor_dn),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] act;
    logic [1:0] up;
    logic [1:0] dn;
    logic [1:0] clr;
    logic [1:0] e_up;
    logic [1:0] e_dn;
    logic [1:0] e_flt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic [1:0] a, input logic [1:0] u, input logic [1:0] d,
                     input logic [1:0] c, input logic [1:0] eu, input logic [1:0] ed,
                     input logic [1:0] ef);
    vec_t v;
    v.act = a; v.up = u; v.dn = d; v.clr = c;
    v.e_up = eu; v.e_dn = ed; v.e_flt = ef;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {motor_up, motor_dn, fault};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got up/dn/fault=%b/%b/%b expected %b/%b/%b",
               name, got[5:4], got[3:2], got[1:0], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  initial begin
    // basic up travel, then reverse to down
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    // timeout: exactly 8 cycles of motor_up, then fault; presses ignored; clear
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 7; i++)
      add(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    // abort and reverse; held level never aborts
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // both limits in EVAL, then during MOVE_DN
    add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // ch0 times out while ch1 travels up, then down
    add(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    add(2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01);
    add(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // ch1: limit and press together -> EVAL, next press goes up again
    add(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    add(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    add(2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    rst_n = 1'b0;
    activate = '0; up_limit = '0; dn_limit = '0; fault_clr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 6'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      activate  = vecs[i].act;
      up_limit  = vecs[i].up;
      dn_limit  = vecs[i].dn;
      fault_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {vecs[i].e_up, vecs[i].e_dn, vecs[i].e_flt});
    end

    // async reset mid-travel with activate held through release
    activate = 2'b01; up_limit = '0; dn_limit = '0; fault_clr = '0;
    @(posedge clk); #1;
    check("rst_seq_move", 6'b01_00_00);
    @(posedge clk); #1;
    check("rst_seq_still_moving", 6'b01_00_00);
    rst_n = 1'b0;
    #1;
    check("rst_async_drop", 6'b0);
    @(posedge clk); #1;
    check("rst_held", 6'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_eval_drop", 6'b0);
    @(posedge clk); #1;
    check("rst_rel_held_level", 6'b0);
    @(posedge clk); #1;
    check("rst_rel_held_level2", 6'b0);
    activate = 2'b00;
    @(posedge clk); #1;
    check("rst_rel_low", 6'b0);
    activate = 2'b01;
    @(posedge clk); #1;
    check("rst_rel_new_edge", 6'b01_00_00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
